// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the hart's single external memory port between the instruction-cache
// refill requester (IC) and the data-memory requester (DM). One transaction at
// a time is placed on the memory bus with registered, stable fields until the
// memory answers or the watchdog expires. A one-cycle response pulse with
// registered read data then goes back to the owner.
//
// Build option: define ARBITER_RR_EN for round-robin arbitration between
// simultaneous requests. Without it, DM always wins because a stalled load or
// store blocks PC advance and has to drain first.
//
// XLEN normally comes from arvi_defines.vh; a 32-bit fallback is provided so
// the block also builds on its own.
`ifndef XLEN
`define XLEN 32
`endif

module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_IC_req,
    input  logic [`XLEN-1:0]  i_IC_addr,
    output logic              o_IC_ready,
    output logic [`XLEN-1:0]  o_IC_data,
    output logic              o_IC_err,
    input  logic              i_DM_req,
    input  logic              i_DM_wen,
    input  logic [`XLEN-1:0]  i_DM_addr,
    input  logic [`XLEN-1:0]  i_DM_wd,
    input  logic [2:0]        i_DM_f3,
    output logic              o_DM_ready,
    output logic [`XLEN-1:0]  o_DM_rdata,
    output logic              o_DM_err,
    output logic [`XLEN-1:0]  o_MEM_addr,
    output logic [`XLEN-1:0]  o_MEM_wd,
    output logic [2:0]        o_MEM_f3,
    output logic              o_MEM_wen,
    output logic              o_MEM_ren,
    input  logic              i_MEM_ready,
    input  logic [`XLEN-1:0]  i_MEM_rdata,
    output logic [1:0]        o_grant
);

    localparam int XW = `XLEN;
    // A zero TIMEOUT still gets a 1-bit counter so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 32'sd1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [XW-1:0]    ZERO_W    = {XW{1'b0}};
    localparam logic [2:0]       IC_F3     = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY_IC = 2'b01,
        ST_BUSY_DM = 2'b10,
        ST_RESP    = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;

    logic req_any_s;
    logic grant_dm_s;
    logic latch_s;
    logic busy_s;
    logic timeout_s;
    logic complete_s;
    logic wen_sel_s;

    logic [1:0] grant_nxt_s;
    logic       mem_ren_nxt_s;
    logic       mem_wen_nxt_s;
    logic       ic_ready_nxt_s;
    logic       dm_ready_nxt_s;

    assign req_any_s  = i_IC_req | i_DM_req;
    assign latch_s    = (state_r == ST_IDLE) && req_any_s;
    assign busy_s     = (state_r == ST_BUSY_IC) || (state_r == ST_BUSY_DM);
    assign timeout_s  = (TIMEOUT != 32'sd0) && (cnt_r == CNT_LIMIT);
    // Memory ready takes precedence over a coinciding timeout.
    assign complete_s = busy_s && (i_MEM_ready || timeout_s);
    // Write-enable that will be on the bus next cycle: freshly latched at grant,
    // otherwise the value already held for the running transaction.
    assign wen_sel_s  = latch_s ? (grant_dm_s & i_DM_wen) : o_MEM_wen;

`ifdef ARBITER_RR_EN
    logic last_dm_r;  // 1 = DM was granted last, 0 = IC (reset value)

    assign grant_dm_s = i_DM_req && (!i_IC_req || !last_dm_r);

    // Remember which requester received the most recent grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_dm_r <= 1'b0;
        end else if (latch_s) begin
            last_dm_r <= grant_dm_s;
        end
    end
`else
    assign grant_dm_s = i_DM_req;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; RESP always returns to IDLE so stale requests are ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    if (grant_dm_s) begin
                        state_nxt_s = ST_BUSY_DM;
                    end else begin
                        state_nxt_s = ST_BUSY_IC;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY_IC, ST_BUSY_DM: begin
                if (complete_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode for the next cycle; results are registered below.
    always_comb begin
        grant_nxt_s    = 2'b00;
        mem_ren_nxt_s  = 1'b0;
        mem_wen_nxt_s  = 1'b0;
        ic_ready_nxt_s = 1'b0;
        dm_ready_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                grant_nxt_s = 2'b00;
            end
            ST_BUSY_IC: begin
                grant_nxt_s   = 2'b01;
                mem_ren_nxt_s = !wen_sel_s;
                mem_wen_nxt_s = wen_sel_s;
            end
            ST_BUSY_DM: begin
                grant_nxt_s   = 2'b10;
                mem_ren_nxt_s = !wen_sel_s;
                mem_wen_nxt_s = wen_sel_s;
            end
            ST_RESP: begin
                // Ownership is kept visible through the response cycle.
                grant_nxt_s    = o_grant;
                ic_ready_nxt_s = (state_r == ST_BUSY_IC);
                dm_ready_nxt_s = (state_r == ST_BUSY_DM);
            end
            default: begin
                grant_nxt_s = 2'b00;
            end
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_grant    <= 2'b00;
            o_MEM_ren  <= 1'b0;
            o_MEM_wen  <= 1'b0;
            o_IC_ready <= 1'b0;
            o_DM_ready <= 1'b0;
        end else begin
            o_grant    <= grant_nxt_s;
            o_MEM_ren  <= mem_ren_nxt_s;
            o_MEM_wen  <= mem_wen_nxt_s;
            o_IC_ready <= ic_ready_nxt_s;
            o_DM_ready <= dm_ready_nxt_s;
        end
    end

    // Sample the winner's fields once at grant; they stay fixed for the transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_MEM_addr <= ZERO_W;
            o_MEM_wd   <= ZERO_W;
            o_MEM_f3   <= 3'b000;
        end else if (latch_s) begin
            if (grant_dm_s) begin
                o_MEM_addr <= i_DM_addr;
                o_MEM_wd   <= i_DM_wd;
                o_MEM_f3   <= i_DM_f3;
            end else begin
                o_MEM_addr <= i_IC_addr;
                o_MEM_wd   <= ZERO_W;
                o_MEM_f3   <= IC_F3;
            end
        end
    end

    // Wait-cycle counter: cleared at grant, counts while busy, saturates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r <= CNT_ZERO;
        end else if (latch_s) begin
            cnt_r <= CNT_ZERO;
        end else if (busy_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Capture the response for the owner; data registers hold between responses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_IC_data  <= ZERO_W;
            o_IC_err   <= 1'b0;
            o_DM_rdata <= ZERO_W;
            o_DM_err   <= 1'b0;
        end else if (complete_s) begin
            if (state_r == ST_BUSY_IC) begin
                o_IC_data <= i_MEM_ready ? i_MEM_rdata : ZERO_W;
                o_IC_err  <= !i_MEM_ready;
            end else begin
                // Stores return zero data.
                o_DM_rdata <= (i_MEM_ready && !o_MEM_wen) ? i_MEM_rdata : ZERO_W;
                o_DM_err   <= !i_MEM_ready;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT = 4).
// A transaction-level model predicts every output each cycle; directed
// scenarios add literal expectations at the interesting cycles.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        i_clk;
    logic        i_rst;
    logic        i_IC_req;
    logic [31:0] i_IC_addr;
    logic        o_IC_ready;
    logic [31:0] o_IC_data;
    logic        o_IC_err;
    logic        i_DM_req;
    logic        i_DM_wen;
    logic [31:0] i_DM_addr;
    logic [31:0] i_DM_wd;
    logic [2:0]  i_DM_f3;
    logic        o_DM_ready;
    logic [31:0] o_DM_rdata;
    logic        o_DM_err;
    logic [31:0] o_MEM_addr;
    logic [31:0] o_MEM_wd;
    logic [2:0]  o_MEM_f3;
    logic        o_MEM_wen;
    logic        o_MEM_ren;
    logic        i_MEM_ready;
    logic [31:0] i_MEM_rdata;
    logic [1:0]  o_grant;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_IC_req(i_IC_req), .i_IC_addr(i_IC_addr),
        .o_IC_ready(o_IC_ready), .o_IC_data(o_IC_data), .o_IC_err(o_IC_err),
        .i_DM_req(i_DM_req), .i_DM_wen(i_DM_wen), .i_DM_addr(i_DM_addr),
        .i_DM_wd(i_DM_wd), .i_DM_f3(i_DM_f3),
        .o_DM_ready(o_DM_ready), .o_DM_rdata(o_DM_rdata), .o_DM_err(o_DM_err),
        .o_MEM_addr(o_MEM_addr), .o_MEM_wd(o_MEM_wd), .o_MEM_f3(o_MEM_f3),
        .o_MEM_wen(o_MEM_wen), .o_MEM_ren(o_MEM_ren),
        .i_MEM_ready(i_MEM_ready), .i_MEM_rdata(i_MEM_rdata),
        .o_grant(o_grant)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 = no transaction, 1 = on the bus, 2 = answering
    int          m_phase  = 0;
    int          m_waited = 0;
    bit          m_valid  = 1'b0;
    bit          m_store  = 1'b0;
    logic [1:0]  m_grant;
    logic        m_ren, m_wen;
    logic [31:0] m_addr, m_wd;
    logic [2:0]  m_f3;
    logic        m_ic_rdy, m_ic_err, m_dm_rdy, m_dm_err;
    logic [31:0] m_ic_data, m_dm_data;
`ifdef ARBITER_RR_EN
    bit          m_last_dm = 1'b0;
`endif

    task automatic model_step();
        bit pick_dm;
        bit ok;
        if (i_rst) begin
            m_phase = 0; m_grant = 2'b00; m_ren = 1'b0; m_wen = 1'b0;
            m_addr = 32'h0; m_wd = 32'h0; m_f3 = 3'b000;
            m_ic_rdy = 1'b0; m_ic_err = 1'b0; m_ic_data = 32'h0;
            m_dm_rdy = 1'b0; m_dm_err = 1'b0; m_dm_data = 32'h0;
`ifdef ARBITER_RR_EN
            m_last_dm = 1'b0;
`endif
            m_valid = 1'b1;
        end else if (m_phase == 0) begin
            m_ic_rdy = 1'b0; m_dm_rdy = 1'b0; m_grant = 2'b00;
            if (i_DM_req || i_IC_req) begin
`ifdef ARBITER_RR_EN
                pick_dm = i_DM_req && (!i_IC_req || !m_last_dm);
                m_last_dm = pick_dm;
`else
                pick_dm = i_DM_req;
`endif
                if (pick_dm) begin
                    m_grant = 2'b10; m_addr = i_DM_addr; m_wd = i_DM_wd;
                    m_f3 = i_DM_f3; m_store = i_DM_wen;
                end else begin
                    m_grant = 2'b01; m_addr = i_IC_addr; m_wd = 32'h0;
                    m_f3 = 3'b010; m_store = 1'b0;
                end
                m_ren = !m_store; m_wen = m_store;
                m_waited = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            ok = (i_MEM_ready === 1'b1);
            if (ok || (TO != 0 && m_waited == TO)) begin
                m_phase = 2; m_ren = 1'b0; m_wen = 1'b0;
                if (m_grant == 2'b01) begin
                    m_ic_rdy = 1'b1; m_ic_err = !ok;
                    m_ic_data = ok ? i_MEM_rdata : 32'h0;
                end else begin
                    m_dm_rdy = 1'b1; m_dm_err = !ok;
                    m_dm_data = (ok && !m_store) ? i_MEM_rdata : 32'h0;
                end
            end else begin
                m_waited++;
            end
        end else begin
            m_phase = 0; m_grant = 2'b00; m_ic_rdy = 1'b0; m_dm_rdy = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            model_step();
        end
    end

    // Compare every output against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (m_valid) begin
                chk("grant",    o_grant,    m_grant);
                chk("mem_ren",  o_MEM_ren,  m_ren);
                chk("mem_wen",  o_MEM_wen,  m_wen);
                chk("mem_addr", o_MEM_addr, m_addr);
                chk("mem_wd",   o_MEM_wd,   m_wd);
                chk("mem_f3",   o_MEM_f3,   m_f3);
                chk("ic_ready", o_IC_ready, m_ic_rdy);
                chk("ic_data",  o_IC_data,  m_ic_data);
                chk("ic_err",   o_IC_err,   m_ic_err);
                chk("dm_ready", o_DM_ready, m_dm_rdy);
                chk("dm_rdata", o_DM_rdata, m_dm_data);
                chk("dm_err",   o_DM_err,   m_dm_err);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit          auto_mem  = 1'b0;
    bit          prev_en   = 1'b0;
    int          txn_cnt   = 0;
    int          dm_pulses = 0;
    logic [31:0] last_dm_data = 32'h0;

    // Advance one cycle; requesters drop the cycle after their response,
    // and the automatic memory answers in the first bus cycle.
    task automatic tick();
        logic icr, dmr;
        icr = o_IC_ready;
        dmr = o_DM_ready;
        @(posedge i_clk);
        #1;
        if (icr === 1'b1) i_IC_req = 1'b0;
        if (dmr === 1'b1) i_DM_req = 1'b0;
        if (o_DM_ready === 1'b1) begin
            dm_pulses++;
            last_dm_data = o_DM_rdata;
        end
        if ((o_MEM_ren === 1'b1 || o_MEM_wen === 1'b1) && !prev_en) txn_cnt++;
        prev_en = (o_MEM_ren === 1'b1) || (o_MEM_wen === 1'b1);
        if (auto_mem) begin
            i_MEM_ready = prev_en;
            i_MEM_rdata = o_MEM_addr ^ 32'h1234_0000;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int t0, p0;

    initial begin
        i_rst = 1'b1; i_IC_req = 1'b1; i_DM_req = 1'b1;
        i_IC_addr = 32'h0000_0400; i_DM_addr = 32'h0000_0010;
        i_DM_wen = 1'b0; i_DM_wd = 32'h0; i_DM_f3 = 3'b010;
        i_MEM_ready = 1'b0; i_MEM_rdata = 32'h0;
        auto_mem = 1'b1;

        // Reset with both requests high, then DM wins, then IC.
        tick(); tick();
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_ren", o_MEM_ren, 1'b0);
        chk("rst_wen", o_MEM_wen, 1'b0);
        chk("rst_ic_ready", o_IC_ready, 1'b0);
        chk("rst_dm_ready", o_DM_ready, 1'b0);
        i_rst = 1'b0;
        tick();
        chk("rst_first_dm", o_grant, 2'b10);
        tick(); tick(); tick();
        chk("rst_then_ic", o_grant, 2'b01);
        repeat (4) tick();

        // IC read, memory ready on the third bus cycle.
        auto_mem = 1'b0;
        i_IC_addr = 32'h0000_0100; i_IC_req = 1'b1;
        tick();
        chk("icrd_ren", o_MEM_ren, 1'b1);
        chk("icrd_f3", o_MEM_f3, 3'b010);
        chk("icrd_addr", o_MEM_addr, 32'h0000_0100);
        tick(); tick();
        i_MEM_ready = 1'b1; i_MEM_rdata = 32'h0050_0093;
        tick();
        i_MEM_ready = 1'b0;
        chk("icrd_ready", o_IC_ready, 1'b1);
        chk("icrd_data", o_IC_data, 32'h0050_0093);
        chk("icrd_err", o_IC_err, 1'b0);
        tick();
        chk("icrd_single_pulse", o_IC_ready, 1'b0);
        tick(); tick();

        // DM load held through its response cycle: one transaction only.
        auto_mem = 1'b1;
        i_DM_addr = 32'h0000_0300; i_DM_wen = 1'b0; i_DM_f3 = 3'b100; i_DM_req = 1'b1;
        t0 = txn_cnt; p0 = dm_pulses;
        repeat (8) tick();
        chk("nodbl_txn", txn_cnt - t0, 1);
        chk("nodbl_resp", dm_pulses - p0, 1);
        chk("nodbl_data", last_dm_data, 32'h1234_0300);

        // Timeout: memory never ready, error response at cycle TO+2.
        auto_mem = 1'b0; i_MEM_ready = 1'b0;
        i_DM_addr = 32'h0000_0040; i_DM_f3 = 3'b010; i_DM_req = 1'b1;
        repeat (5) tick();
        chk("to_not_yet", o_DM_ready, 1'b0);
        chk("to_still_busy", o_MEM_ren, 1'b1);
        tick();
        chk("to_ready", o_DM_ready, 1'b1);
        chk("to_err", o_DM_err, 1'b1);
        chk("to_rdata", o_DM_rdata, 32'h0);
        chk("to_ren_low", o_MEM_ren, 1'b0);
        repeat (3) tick();

        // Simultaneous IC read and DM store.
        auto_mem = 1'b1;
        i_IC_addr = 32'h0000_0200; i_DM_addr = 32'h0000_0080;
        i_DM_wen = 1'b1; i_DM_wd = 32'hDEAD_BEEF; i_DM_f3 = 3'b010;
        i_IC_req = 1'b1; i_DM_req = 1'b1;
        tick();
`ifdef ARBITER_RR_EN
        chk("sim_first_grant", o_grant, 2'b01);
        chk("sim_first_addr", o_MEM_addr, 32'h0000_0200);
        chk("sim_first_ren", o_MEM_ren, 1'b1);
`else
        chk("sim_first_grant", o_grant, 2'b10);
        chk("sim_first_wen", o_MEM_wen, 1'b1);
        chk("sim_first_wd", o_MEM_wd, 32'hDEAD_BEEF);
        chk("sim_first_addr", o_MEM_addr, 32'h0000_0080);
`endif
        tick(); tick(); tick();
`ifdef ARBITER_RR_EN
        chk("sim_second_grant", o_grant, 2'b10);
        chk("sim_second_wen", o_MEM_wen, 1'b1);
        chk("sim_second_wd", o_MEM_wd, 32'hDEAD_BEEF);
`else
        chk("sim_second_grant", o_grant, 2'b01);
        chk("sim_second_ren", o_MEM_ren, 1'b1);
        chk("sim_second_addr", o_MEM_addr, 32'h0000_0200);
`endif
        repeat (4) tick();
        i_DM_wen = 1'b0;

        // Reset pulsed while a DM load is on the bus.
        auto_mem = 1'b0; i_MEM_ready = 1'b0;
        i_DM_addr = 32'h0000_0044; i_DM_req = 1'b1;
        tick();
        chk("rstmid_busy", o_MEM_ren, 1'b1);
        tick();
        i_rst = 1'b1; i_DM_req = 1'b0;
        tick();
        chk("rstmid_ren", o_MEM_ren, 1'b0);
        chk("rstmid_grant", o_grant, 2'b00);
        i_rst = 1'b0;
        p0 = dm_pulses;
        repeat (4) tick();
        chk("rstmid_no_resp", dm_pulses - p0, 0);
        chk("rstmid_idle", o_grant, 2'b00);
        auto_mem = 1'b1;
        i_IC_addr = 32'h0000_0500; i_IC_req = 1'b1;
        tick();
        chk("rstmid_regrant", o_grant, 2'b01);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port of the hart between the instruction-cache refill requester and the data-memory requester. It accepts one transaction at a time and drives it on the memory bus with stable, registered signals until the memory reports ready. It then returns a one-cycle response, with registered read data, to the requester that was granted. The block sits between `I_CACHE` / `DATA_MEMORY_V2` and the system memory, and includes a bus-timeout watchdog.

## Interface
- `TIMEOUT`, default 255: maximum cycles a granted transaction waits for `i_MEM_ready`. 0 disables the watchdog.
- `XLEN` comes from `arvi_defines.vh`. It is not a parameter.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_IC_req`  in  1  instruction refill request; held until `o_IC_ready`.
- `i_IC_addr`  in  XLEN  refill address.
- `o_IC_ready`  out  1  one-cycle response pulse.
- `o_IC_data`  out  XLEN  read data; valid while `o_IC_ready`=1.
- `o_IC_err`  out  1  timeout flag; valid while `o_IC_ready`=1.
- `i_DM_req`  in  1  data request; held until `o_DM_ready`.
- `i_DM_wen`  in  1  1 = store, 0 = load.
- `i_DM_addr`  in  XLEN  data address.
- `i_DM_wd`  in  XLEN  store data.
- `i_DM_f3`  in  3  access size/sign (RISC-V funct3).
- `o_DM_ready`  out  1  one-cycle response pulse.
- `o_DM_rdata`  out  XLEN  load data; valid while `o_DM_ready`=1.
- `o_DM_err`  out  1  timeout flag; valid while `o_DM_ready`=1.
- `o_MEM_addr`  out  XLEN  memory address.
- `o_MEM_wd`  out  XLEN  memory write data.
- `o_MEM_f3`  out  3  memory access size.
- `o_MEM_wen`  out  1  memory write enable.
- `o_MEM_ren`  out  1  memory read enable.
- `i_MEM_ready`  in  1  memory completion.
- `i_MEM_rdata`  in  XLEN  memory read data.
- `o_grant`  out  2  current owner: `01` = IC, `10` = DM, `00` = none.

## Operation
States:
- **IDLE**
  - If any request is pending, arbitrate and latch the winner's address, write data, f3 and wen.
  - Go to BUSY_IC or BUSY_DM.
  - An IC grant latches f3=`3'b010`, wen=0 and wd=0.
- **BUSY_IC / BUSY_DM**
  - Drive the latched fields onto `o_MEM_*`. `o_MEM_ren` = !wen and `o_MEM_wen` = wen; exactly one of the two is high.
  - Count wait cycles.
  - On `i_MEM_ready`=1: capture `i_MEM_rdata` into the owner's data register (stores capture 0), clear err, go to RESP.
  - On the counter reaching `TIMEOUT` (`TIMEOUT`≠0) without ready: data=0, err=1, go to RESP.
- **RESP**
  - Pulse the owner's ready for exactly one cycle; `o_MEM_ren`/`o_MEM_wen` are 0.
  - Ignore all requests this cycle, because the requester still presents the stale request while consuming the response.
  - Go to IDLE.

Rules:
- Arbitration is fixed DM priority: a stalled load or store blocks PC advance, so it must drain first.
- Requests arriving while busy wait; they are never dropped.
- Requester fields are sampled only at grant. Later changes in the same transaction are ignored.
- The wait counter is `$clog2(TIMEOUT+1)` bits wide, clears at grant and saturates; it never wraps.
- `o_IC_data` and `o_DM_rdata` hold their last value outside RESP.
- If `i_MEM_ready` and timeout coincide on the same cycle, ready wins: err=0 and the data is real.
- `i_MEM_ready` is ignored in IDLE and RESP.

## Timing
- Reset: all outputs are 0, state is IDLE, the counter is 0 and the last-grant bit points to IC.
- Reset during BUSY abandons the transaction. `o_MEM_ren`/`o_MEM_wen` drop on the next edge and no response is issued.
- Request asserted at cycle 0 while IDLE: `o_MEM_*` valid at cycle 1.
- Memory ready at cycle N≥1: response pulse at cycle N+1; the next grant is possible at cycle N+3 if a request is pending in IDLE at N+2.
- Minimum occupancy: 3 cycles per transaction when memory answers at cycle 1.
- Timeout: with `TIMEOUT`=T, the err response pulses at cycle T+2 after the request.
- `o_MEM_*` are registered, with no combinational path from requester inputs to the memory outputs.
- The only combinational path from `i_MEM_*` is into the capture registers.

## Configuration
- `ARBITER_RR_EN` defined: round-robin arbitration.
  - On simultaneous requests in IDLE, the requester not granted last wins.
  - A single request is granted immediately regardless of history.
  - Last-grant updates at each grant.
- `ARBITER_RR_EN` undefined: fixed DM priority; the last-grant register is not implemented.

## Test plan
- Reset: hold `i_rst`=1 for 2 cycles with both requests high. Expect all outputs 0, `o_grant`=00 and no memory enable. Release: DM is granted first.
- IC read: `i_IC_addr`=0x100, memory ready on the 3rd busy cycle with rdata 0x00500093. Expect `o_MEM_ren`=1, `o_MEM_f3`=010 and a single `o_IC_ready` pulse with `o_IC_data`=0x00500093, `o_IC_err`=0.
- Simultaneous requests: IC 0x200 and DM store of 0xDEADBEEF to 0x80 with f3=010. Without the macro: DM first (`o_MEM_wen`=1, wd=0xDEADBEEF), then IC. With `ARBITER_RR_EN` and last grant = DM: IC first.
- No double issue: DM load held high through its `o_DM_ready` cycle and dropped the cycle after. Expect exactly one memory transaction.
- Timeout: `TIMEOUT`=4, DM load with the memory never ready. Expect `o_DM_ready`=1 and `o_DM_err`=1 with rdata 0 at cycle 6, and `o_MEM_ren` low at that cycle.
- Reset mid-transaction: `i_rst` pulsed in BUSY_DM. Expect `o_MEM_ren`=0 on the next edge, no `o_DM_ready`, and the FSM back in IDLE.
